// File: rtl/pic_cpu_bus_master.sv
// CPU-side bus initiator for an 8259A-style PIC: turns single-cycle host requests into timed
// SETUP/STROBE/HOLD write and read cycles on the CSn/A0/cadr/wrn/rdn/data interface.
module pic_cpu_bus_master #(
  parameter int unsigned T_SU = 1,
  parameter int unsigned T_PW = 2,
  parameter int unsigned T_HD = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       init_req,
  input  logic [7:0] icw1,
  input  logic [7:0] icw2,
  input  logic [7:0] icw3,
  input  logic [7:0] icw4,
  input  logic       ocw_req,
  input  logic [1:0] ocw_sel,
  input  logic [7:0] ocw_data,
  input  logic       rd_req,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       CSn,
  output logic       A0,
  output logic       wrn,
  output logic       rdn,
  output logic [2:0] cadr,
  output logic [7:0] dbus_out,
  output logic       dbus_oe,
  input  logic [7:0] dbus_in
);

  typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StGap} state_e;

  localparam logic [7:0] SuCnt = 8'(T_SU - 1);
  localparam logic [7:0] PwCnt = 8'(T_PW - 1);
  localparam logic [7:0] HdCnt = 8'(T_HD - 1);

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [3:0]      pend_q, pend_d;  // ICWs still to issue, bit n = ICW(n+1)
  logic [3:0][7:0] icw_q, icw_d;
  logic            is_rd_q, is_rd_d;
  logic [7:0]      rd_buf_q, rd_buf_d;
  logic            busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic            rd_valid_q, rd_valid_d;
  logic            csn_q, csn_d, a0_q, a0_d, wrn_q, wrn_d, rdn_q, rdn_d;
  logic [2:0]      cadr_q, cadr_d;
  logic [7:0]      dbus_out_q, dbus_out_d;
  logic            dbus_oe_q, dbus_oe_d;
  logic [1:0]      nxt_idx;

  always_comb begin
    if (pend_q[0])      nxt_idx = 2'd0;
    else if (pend_q[1]) nxt_idx = 2'd1;
    else if (pend_q[2]) nxt_idx = 2'd2;
    else                nxt_idx = 2'd3;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    icw_d      = icw_q;
    is_rd_d    = is_rd_q;
    rd_buf_d   = rd_buf_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    csn_d      = csn_q;
    a0_d       = a0_q;
    wrn_d      = wrn_q;
    rdn_d      = rdn_q;
    cadr_d     = cadr_q;
    dbus_out_d = dbus_out_q;
    dbus_oe_d  = dbus_oe_q;
    unique case (state_q)
      StIdle: begin
        if (init_req) begin
          if (!icw1[4]) begin
            err_d = 1'b1;
          end else begin
            state_d    = StSetup;
            cnt_d      = SuCnt;
            busy_d     = 1'b1;
            csn_d      = 1'b0;
            is_rd_d    = 1'b0;
            icw_d      = {icw4, icw3, icw2, icw1};
            pend_d     = {icw1[0], ~icw1[1], 1'b1, 1'b0};
            cadr_d     = 3'b001;
            a0_d       = 1'b0;
            dbus_out_d = icw1;
            dbus_oe_d  = 1'b1;
          end
        end else if (ocw_req) begin
          if (ocw_sel == 2'b00) begin
            err_d = 1'b1;
          end else begin
            state_d    = StSetup;
            cnt_d      = SuCnt;
            busy_d     = 1'b1;
            csn_d      = 1'b0;
            is_rd_d    = 1'b0;
            pend_d     = '0;
            cadr_d     = {1'b1, ocw_sel};
            a0_d       = (ocw_sel == 2'b01);
            dbus_out_d = ocw_data;
            dbus_oe_d  = 1'b1;
          end
        end else if (rd_req) begin
          state_d   = StSetup;
          cnt_d     = SuCnt;
          busy_d    = 1'b1;
          csn_d     = 1'b0;
          is_rd_d   = 1'b1;
          pend_d    = '0;
          cadr_d    = 3'b111;
          a0_d      = 1'b0;
          dbus_oe_d = 1'b0;
        end
      end
      StSetup: begin
        if (cnt_q == '0) begin
          state_d = StStrobe;
          cnt_d   = PwCnt;
          if (is_rd_q) rdn_d = 1'b0;
          else         wrn_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StStrobe: begin
        if (cnt_q == '0) begin
          if (is_rd_q) rd_buf_d = dbus_in;  // sampled before rdn rises
          state_d = StHold;
          cnt_d   = HdCnt;
          wrn_d   = 1'b1;
          rdn_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          csn_d     = 1'b1;
          dbus_oe_d = 1'b0;
          if (pend_q != '0) begin
            state_d = StGap;
          end else begin
            state_d    = StIdle;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            a0_d       = 1'b0;
            cadr_d     = 3'b000;
            dbus_out_d = 8'h00;
            if (is_rd_q) begin
              rd_data_d  = rd_buf_q;
              rd_valid_d = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StGap: begin
        state_d         = StSetup;
        cnt_d           = SuCnt;
        csn_d           = 1'b0;
        cadr_d          = {1'b0, nxt_idx} + 3'd1;
        a0_d            = (nxt_idx != 2'd0);
        dbus_out_d      = icw_q[nxt_idx];
        dbus_oe_d       = 1'b1;
        pend_d[nxt_idx] = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      pend_q     <= '0;
      icw_q      <= '0;
      is_rd_q    <= 1'b0;
      rd_buf_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      csn_q      <= 1'b1;
      a0_q       <= 1'b0;
      wrn_q      <= 1'b1;
      rdn_q      <= 1'b1;
      cadr_q     <= '0;
      dbus_out_q <= '0;
      dbus_oe_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      icw_q      <= icw_d;
      is_rd_q    <= is_rd_d;
      rd_buf_q   <= rd_buf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      csn_q      <= csn_d;
      a0_q       <= a0_d;
      wrn_q      <= wrn_d;
      rdn_q      <= rdn_d;
      cadr_q     <= cadr_d;
      dbus_out_q <= dbus_out_d;
      dbus_oe_q  <= dbus_oe_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign CSn      = csn_q;
  assign A0       = a0_q;
  assign wrn      = wrn_q;
  assign rdn      = rdn_q;
  assign cadr     = cadr_q;
  assign dbus_out = dbus_out_q;
  assign dbus_oe  = dbus_oe_q;

endmodule

// File: tb/tb_pic_cpu_bus_master.sv
// Scoreboard bench for pic_cpu_bus_master: requests push expected bus cycles and completions,
// a negedge monitor reconstructs what the DUT did on the bus and pops/compares.
module tb_pic_cpu_bus_master;

  localparam int TSu = 1;
  localparam int TPw = 2;
  localparam int THd = 1;
  localparam int KWr = 0, KRd = 1, KDone = 2, KErr = 3;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       init_req = 1'b0, ocw_req = 1'b0, rd_req = 1'b0;
  logic [7:0] icw1 = '0, icw2 = '0, icw3 = '0, icw4 = '0, ocw_data = '0;
  logic [1:0] ocw_sel = '0;
  logic [7:0] dbus_in = '0;
  logic       busy, done, err, rd_valid, CSn, A0, wrn, rdn, dbus_oe;
  logic [7:0] rd_data, dbus_out;
  logic [2:0] cadr;

  pic_cpu_bus_master #(.T_SU(TSu), .T_PW(TPw), .T_HD(THd)) dut (
    .clk(clk), .rstn(rstn), .init_req(init_req), .icw1(icw1), .icw2(icw2), .icw3(icw3),
    .icw4(icw4), .ocw_req(ocw_req), .ocw_sel(ocw_sel), .ocw_data(ocw_data), .rd_req(rd_req),
    .busy(busy), .done(done), .err(err), .rd_data(rd_data), .rd_valid(rd_valid), .CSn(CSn),
    .A0(A0), .wrn(wrn), .rdn(rdn), .cadr(cadr), .dbus_out(dbus_out), .dbus_oe(dbus_oe),
    .dbus_in(dbus_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int cadr;
    int a0;
    int data;
    int busy;
    int rdv;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] rd_val = 8'h00;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void push(input int kind, input int c, input int a, input int d,
                               input int b, input int v);
    exp_t e;
    e.kind = kind; e.cadr = c; e.a0 = a; e.data = d; e.busy = b; e.rdv = v;
    exp_q.push_back(e);
  endfunction

  // Reference model: what one request should produce, from the register map and sequencing rules.
  function automatic void model(input bit ini, input bit ocw, input bit rd, input logic [7:0] i1,
                                input logic [7:0] i2, input logic [7:0] i3, input logic [7:0] i4,
                                input logic [1:0] sel, input logic [7:0] od, input logic [7:0] rv);
    int cyc = TSu + TPw + THd;
    int n;
    if (ini) begin
      if (!i1[4]) begin
        push(KErr, 0, 0, 0, 0, 0);
      end else begin
        push(KWr, 1, 0, i1, 0, 0);
        push(KWr, 2, 1, i2, 0, 0);
        n = 2;
        if (!i1[1]) begin push(KWr, 3, 1, i3, 0, 0); n++; end
        if (i1[0])  begin push(KWr, 4, 1, i4, 0, 0); n++; end
        push(KDone, 0, 0, 0, n * cyc + (n - 1), 0);
      end
    end else if (ocw) begin
      case (sel)
        2'b01:   push(KWr, 5, 1, od, 0, 0);
        2'b10:   push(KWr, 6, 0, od, 0, 0);
        2'b11:   push(KWr, 7, 0, od, 0, 0);
        default: push(KErr, 0, 0, 0, 0, 0);
      endcase
      if (sel != 2'b00) push(KDone, 0, 0, 0, cyc, 0);
    end else if (rd) begin
      push(KRd, 7, 0, 0, 0, 0);
      push(KDone, 0, 0, rv, cyc, 1);
    end
  endfunction

  task automatic issue(input bit ini, input bit ocw, input bit rd, input logic [7:0] i1,
                       input logic [7:0] i2, input logic [7:0] i3, input logic [7:0] i4,
                       input logic [1:0] sel, input logic [7:0] od, input logic [7:0] rv);
    @(posedge clk); #1;
    rd_val = rv;
    model(ini, ocw, rd, i1, i2, i3, i4, sel, od, rv);
    init_req = ini; ocw_req = ocw; rd_req = rd;
    icw1 = i1; icw2 = i2; icw3 = i3; icw4 = i4; ocw_sel = sel; ocw_data = od;
    @(posedge clk); #1;
    init_req = 1'b0; ocw_req = 1'b0; rd_req = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", int'(n < 300), 1);
    repeat (2) @(negedge clk);
  endtask

  // PIC model for reads: the valid byte appears only on the last strobe cycle.
  int rd_cyc = 0;
  always @(negedge clk) begin
    if (!rdn) rd_cyc++;
    else      rd_cyc = 0;
    dbus_in = (!rdn && rd_cyc == TPw) ? rd_val : ~rd_val;
  end

  // Monitor
  bit         in_seg = 0, saw_wr = 0, saw_rd = 0, oe_any = 0, oe_str = 0;
  int         su = 0, pw = 0, hd = 0, busy_cnt = 0, mcadr = 0, ma0 = 0, wdata = 0;

  task automatic pop_exp(output exp_t e, output bit ok);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event: got an output event expected none at %0t", $time);
      ok = 0;
    end else begin
      e  = exp_q.pop_front();
      ok = 1;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    int   k;
    if (!rstn) begin
      in_seg   = 0;
      busy_cnt = 0;
    end else begin
      chk("strobe_excl", int'(!wrn && !rdn), 0);
      chk("strobe_cs", int'((!wrn || !rdn) && CSn), 0);
      chk("oe_in_read", int'(!rdn && dbus_oe), 0);
      chk("rdv_no_done", int'(rd_valid && !done), 0);
      if (!CSn) begin
        if (!in_seg) begin
          in_seg = 1; su = 0; pw = 0; hd = 0; saw_wr = 0; saw_rd = 0; oe_any = 0; oe_str = 0;
        end
        if (!wrn || !rdn) begin
          pw++;
          if (!wrn) begin saw_wr = 1; wdata = dbus_out; oe_str = dbus_oe; end
          if (!rdn) saw_rd = 1;
        end else if (pw == 0) su++;
        else hd++;
        if (dbus_oe) oe_any = 1;
        mcadr = cadr;
        ma0   = A0;
      end else if (in_seg) begin
        in_seg = 0;
        pop_exp(e, ok);
        if (ok) begin
          k = saw_rd ? KRd : (saw_wr ? KWr : -1);
          chk("bus_kind", k, e.kind);
          chk("bus_cadr", mcadr, e.cadr);
          chk("bus_a0", ma0, e.a0);
          if (k == KWr) begin
            chk("wr_data", wdata, e.data);
            chk("wr_oe", int'(oe_str), 1);
          end
          if (k == KRd) chk("rd_oe", int'(oe_any), 0);
          chk("t_su", su, TSu);
          chk("t_pw", pw, TPw);
          chk("t_hd", hd, THd);
        end
      end
      if (busy) busy_cnt++;
      if (done) begin
        pop_exp(e, ok);
        if (ok) begin
          chk("done_kind", KDone, e.kind);
          chk("busy_cycles", busy_cnt, e.busy);
          chk("rd_valid", int'(rd_valid), e.rdv);
          if (e.rdv != 0) chk("rd_data", rd_data, e.data);
        end
        busy_cnt = 0;
      end
      if (err) begin
        pop_exp(e, ok);
        if (ok) begin
          chk("err_kind", KErr, e.kind);
          chk("err_busy", busy_cnt, 0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [2:0] r;
    logic [7:0] i1;
    #12;
    chk("rst_csn", CSn, 1);
    chk("rst_wrn", wrn, 1);
    chk("rst_rdn", rdn, 1);
    chk("rst_a0", A0, 0);
    chk("rst_cadr", cadr, 0);
    chk("rst_dout", dbus_out, 0);
    chk("rst_oe", dbus_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_valid", rd_valid, 0);
    #10 rstn = 1'b1;

    issue(1, 0, 0, 8'h11, 8'h20, 8'h04, 8'h01, 2'b00, 8'h00, 8'h00);  // full init
    wait_idle();
    issue(1, 0, 0, 8'h12, 8'h20, 8'h04, 8'h01, 2'b00, 8'h00, 8'h00);  // single, no ICW4
    wait_idle();
    issue(1, 0, 0, 8'h01, 8'h20, 8'h04, 8'h01, 2'b00, 8'h00, 8'h00);  // illegal ICW1
    wait_idle();
    issue(0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 2'b11, 8'h0A, 8'h00);
    wait_idle();
    issue(0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 8'h00, 8'h5C);
    wait_idle();
    issue(0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 8'h33, 8'h00);  // reserved OCW
    wait_idle();
    issue(1, 1, 1, 8'h13, 8'hA8, 8'h00, 8'h00, 2'b01, 8'hFF, 8'h77);  // priority
    wait_idle();

    // OCW raised mid-init must be ignored
    issue(1, 0, 0, 8'h11, 8'h40, 8'h02, 8'h03, 2'b00, 8'h00, 8'h00);
    repeat (5) @(posedge clk);
    #1 ocw_req = 1'b1; ocw_sel = 2'b11; ocw_data = 8'hEE;
    @(posedge clk); #1 ocw_req = 1'b0;
    repeat (4) @(posedge clk);
    #1 rd_req = 1'b1;
    @(posedge clk); #1 rd_req = 1'b0;
    wait_idle();

    // Reset during a write strobe
    issue(1, 0, 0, 8'h11, 8'h20, 8'h04, 8'h01, 2'b00, 8'h00, 8'h00);
    n = 0;
    while (wrn !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reach_strobe", int'(n < 50), 1);
    rstn = 1'b0;
    #1;
    chk("abort_wrn", wrn, 1);
    chk("abort_csn", CSn, 1);
    chk("abort_busy", busy, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (5) @(negedge clk);
    issue(0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 8'h00, 8'h3C);
    wait_idle();

    for (int it = 0; it < 40; it++) begin
      r  = 3'($urandom_range(0, 7));
      i1 = 8'($urandom);
      if ($urandom_range(0, 4) != 0) i1[4] = 1'b1;
      issue(r[0], r[1], r[2], i1, 8'($urandom), 8'($urandom), 8'($urandom),
            2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
      wait_idle();
    end

    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pic_cpu_bus_master.md
Name: pic_cpu_bus_master

Overview:
- CPU-side bus initiator that programs and interrogates the 8259A-style controller over its rdn/wrn/A0/CSn/cadr/data interface.
- Converts single-cycle host requests into correctly timed bus write and read cycles:
  - full ICW initialisation sequence;
  - single OCW writes;
  - status reads.
- Sits between the host/testbench controller logic and the PIC read/write logic and data bus buffer.

Parameters:
- T_SU, 1: clk cycles CSn/A0/cadr/data are stable before the strobe falls (min 1).
- T_PW, 2: clk cycles rdn or wrn is held low (min 1).
- T_HD, 1: clk cycles CSn/A0/cadr/data are held after the strobe rises (min 1).

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- init_req  input  1  start ICW sequence (1-cycle pulse).
- icw1, icw2, icw3, icw4  input  8 each  ICW values, sampled when init_req is accepted.
- ocw_req  input  1  start one OCW write.
- ocw_sel  input  2  01=OCW1, 10=OCW2, 11=OCW3, 00=reserved.
- ocw_data  input  8  OCW value, sampled with ocw_req.
- rd_req  input  1  start one status read.
- busy  output  1  high from acceptance until the final hold phase ends.
- done  output  1  1-cycle pulse when a request completes.
- err  output  1  1-cycle pulse when a request is rejected.
- rd_data  output  8  last captured read byte.
- rd_valid  output  1  1-cycle pulse when rd_data is updated.
- CSn  output  1  chip select, active low.
- A0  output  1  address bit.
- wrn  output  1  write strobe, active low.
- rdn  output  1  read strobe, active low.
- cadr  output  3  register code.
- dbus_out  output  8  write data.
- dbus_oe  output  1  high while driving dbus_out.
- dbus_in  input  8  read data from the PIC.

Behaviour:
- Reset (async, rstn=0) forces:
  - CSn=1, wrn=1, rdn=1, A0=0, cadr=000;
  - dbus_out=00, dbus_oe=0, busy=0, done=0, err=0;
  - rd_data=00, rd_valid=0;
  - FSM to IDLE, all counters and latches cleared.
- Reset mid-cycle aborts immediately, with no done pulse. Outputs are registered.
- Acceptance:
  - Requests are sampled only in IDLE. Requests while busy=1 are ignored.
  - Priority on simultaneous requests: init_req > ocw_req > rd_req. Losers are dropped.
  - The accepted request raises busy on the next cycle.
- Register map (cadr / A0):
  - ICW1 001/0, ICW2 010/1, ICW3 011/1, ICW4 100/1;
  - OCW1 101/1, OCW2 110/0, OCW3 111/0;
  - status read 111/0.
- One bus cycle = SETUP → STROBE → HOLD:
  - SETUP, T_SU cycles: CSn=0, A0 and cadr valid. For writes, dbus_oe=1 and dbus_out=data.
  - STROBE, T_PW cycles: wrn=0 (write) or rdn=0 (read). Other signals held.
  - HOLD, T_HD cycles: strobe=1, everything else held.
  - After HOLD, return to IDLE or chain to the next cycle.
  - Between chained cycles, CSn returns to 1 and dbus_oe to 0 for exactly 1 cycle (GAP state).
- Init sequence:
  - ICW1, then ICW2.
  - ICW3 only if icw1[1]=0.
  - ICW4 only if icw1[0]=1.
  - done is pulsed in the cycle after the final HOLD; busy falls in the same cycle.
- Init validation: if icw1[4]=0, raise err for 1 cycle, issue no bus cycle, stay IDLE, busy never rises.
- OCW:
  - A single write cycle.
  - ocw_sel=00 is treated as an error: err pulse, no bus cycle.
- Read:
  - dbus_in is captured on the last STROBE cycle, before rdn rises.
  - rd_data and rd_valid are updated together with done.
  - dbus_oe=0 throughout a read.
- Invariants:
  - wrn and rdn are never low simultaneously.
  - A strobe is never low while CSn=1.
  - dbus_oe is never 1 during a read.
- Cycle count, single cycle: T_SU+T_PW+T_HD. Chained: +1 GAP per additional cycle.

Test Plan:
- Full init, default params: icw1=0x11, icw2=0x20, icw3=0x04, icw4=0x01 → 4 write cycles with cadr 001/010/011/100 and A0 0/1/1/1. Each cycle has wrn low exactly 2 clk; total 4×4+3=19 busy cycles, then a done pulse.
- Single mode, no ICW4: icw1=0x12 → only ICW1 and ICW2 cycles; ICW3/ICW4 are never driven; done after 9 cycles.
- Illegal ICW1: icw1=0x01 with init_req → err pulse 1 cycle; CSn stays 1; busy stays 0.
- OCW write then read: ocw_sel=11, ocw_data=0x0A → cadr=111, A0=0, wrn pulse. Then rd_req with dbus_in=0x5C during STROBE → rd_data=0x5C, rd_valid pulse, and dbus_oe=0 throughout.
- Simultaneous/busy requests: init_req, ocw_req and rd_req together → only the init sequence runs. An ocw_req raised mid-sequence is ignored (no extra wrn pulse).
- Reset mid-STROBE: rstn=0 while wrn=0 → wrn=1, CSn=1, busy=0 immediately. After release, a new rd_req completes normally.
